uart_tx_buffered: RTL and testbench

Memory-mapped, buffered UART transmitter on the CPU data channel (channel 2), replacing the direct store-to-serializer path. CPU byte stores to the data address enter a byte FIFO. An 8N1 serializer drains the FIFO onto `uart_tx`. A status word is readable so firmware can poll instead of overrunning.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_byte_fifo.sv | 62 ++++++
 rtl/uart_tx_buffered.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer states,
// status-word bit positions and default register addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_OVF      = 3;
  localparam int STAT_CNT_LSB  = 8;
  localparam int STAT_DROP_LSB = 16;

  localparam logic [31:0] DEF_ADDR_DATA = 32'h0000_01f0;
  localparam logic [31:0] DEF_ADDR_STAT = 32'h0000_01f4;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO for the UART transmitter. Pointers carry one extra wrap bit so
// full and empty are distinguished by count = wptr - rptr.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  din,
  input  logic        pop,
  output logic [7:0]  dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  typedef logic [AW:0] ptr_t;

  logic [7:0] mem [DEPTH];
  ptr_t       wptr_q, wptr_d;
  ptr_t       rptr_q, rptr_d;
  logic       push_ok;
  logic       pop_ok;

  assign count = wptr_q - rptr_q;
  assign full  = (count == ptr_t'(DEPTH));
  assign empty = (wptr_q == rptr_q);
  assign dout  = mem[rptr_q[AW-1:0]];

  // A push into a full FIFO is still taken when a pop frees a slot that cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  // Next-pointer arithmetic; pointers wrap naturally through the extra bit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + ptr_t'(1);
    if (pop_ok)  rptr_d = rptr_q + ptr_t'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; stale entries are unreachable once the pointers clear.
    if (push_ok) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Memory-mapped buffered 8N1 UART transmitter. Byte stores to ADDR_DATA fill
// a FIFO that the serializer drains onto uart_tx; ADDR_STAT returns a status
// word. The SoC integration gates the D-cache write enable on either address.
// Optional build macro: UART_TX_DROPCNT_EN adds an 8-bit saturating count of
// discarded pushes at status [23:16].
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ  = 100000000,
  parameter int          BAUD      = 115200,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] ADDR_DATA = DEF_ADDR_DATA,
  parameter logic [31:0] ADDR_STAT = DEF_ADDR_STAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] add,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        uart_tx,
  output logic        busy
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;

  logic          hit_data, hit_stat;
  logic          push, push_ok, pop, drop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_d;
  logic [7:0]    drop_cnt;
  logic [31:0]   stat;
  logic          unused_wdata;

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          sel_q, sel_d;
  logic [31:0]   rdata_q, rdata_d;

  assign hit_data     = (add == ADDR_DATA);
  assign hit_stat     = (add == ADDR_STAT);
  assign push         = hit_data && (|wen);
  assign push_ok      = push && (!fifo_full || pop);
  assign drop         = push && fifo_full && !pop;
  assign unused_wdata = ^wdata[31:8];

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wdata[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef UART_TX_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of discarded pushes, cleared only by reset.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hff)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

  // Serializer next state: start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == BW'(DIV - 1)) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (baud_q == BW'(DIV - 1)) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_q == BW'(DIV - 1)) begin
          state_d = ST_IDLE;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Busy and sticky overflow as they will stand after this edge.
  always_comb begin
    count_d = fifo_count + CW'(push_ok) - CW'(pop);
    busy_d  = (state_d != ST_IDLE) || (count_d != '0);
    ovf_d   = ovf_q | drop;
  end

  // Status word and bus read path, sampled from pre-edge state.
  always_comb begin
    stat                         = '0;
    stat[STAT_BUSY]              = busy_q;
    stat[STAT_FULL]              = fifo_full;
    stat[STAT_EMPTY]             = fifo_empty;
    stat[STAT_OVF]               = ovf_q;
    stat[STAT_CNT_LSB +: 8]      = 8'(fifo_count);
    stat[STAT_DROP_LSB +: 8]     = drop_cnt;
    sel_d                        = hit_data || hit_stat;
    rdata_d                      = hit_stat ? stat : 32'h0;
  end

  // Serializer, status and bus registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign sel     = sel_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered at DIV=10, DEPTH=4. A queue-and-frame-time model
// predicts uart_tx, busy, sel and rdata every cycle; directed scenarios add
// literal expectations for latency, bit order, status words and reset abort.
module tb_uart_tx_buffered;

  localparam int          CLK_FREQ  = 1000;
  localparam int          BAUD      = 100;
  localparam int          DIV       = CLK_FREQ / BAUD;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] ADDR_DATA = 32'h0000_01f0;
  localparam logic [31:0] ADDR_STAT = 32'h0000_01f4;
`ifdef UART_TX_DROPCNT_EN
  localparam logic [31:0] DROP1     = 32'h0001_0000;
`else
  localparam logic [31:0] DROP1     = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] add;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;
  logic        uart_tx;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DEPTH     (DEPTH),
    .ADDR_DATA (ADDR_DATA),
    .ADDR_STAT (ADDR_STAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .add     (add),
    .wen     (wen),
    .wdata   (wdata),
    .rdata   (rdata),
    .sel     (sel),
    .uart_tx (uart_tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  q[$];
  bit          in_frame  = 0;
  int          t         = 0;
  logic [7:0]  cur       = 8'h00;
  bit          ovf       = 0;
  int          drops     = 0;
  bit          model_on  = 0;
  int          cyc       = 0;
  int          start_cyc = 0;
  logic [31:0] exp_rdata = '0;
  bit          exp_sel   = 0;
  bit          exp_tx    = 1;
  bit          exp_busy  = 0;

  // Line level at time t into a frame: start, 8 data bits LSB first, stop.
  function automatic bit frame_bit(input logic [7:0] b, input int tt);
    int k;
    k = tt / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = exp_busy;
    s[1]     = (q.size() == DEPTH);
    s[2]     = (q.size() == 0);
    s[3]     = ovf;
    s[15:8]  = 8'(q.size());
`ifdef UART_TX_DROPCNT_EN
    s[23:16] = 8'(drops);
`endif
    return s;
  endfunction

  task automatic model_step();
    bit push;
    bit did_pop;
    int pre_size;
    cyc++;
    if (reset) begin
      q.delete();
      in_frame  = 0;
      t         = 0;
      ovf       = 0;
      drops     = 0;
      exp_rdata = '0;
      exp_sel   = 0;
      exp_tx    = 1;
      exp_busy  = 0;
      model_on  = 1;
      return;
    end
    exp_sel   = (add == ADDR_DATA) || (add == ADDR_STAT);
    exp_rdata = (add == ADDR_STAT) ? model_status() : 32'h0;
    push      = (add == ADDR_DATA) && (wen != 4'b0);
    pre_size  = q.size();
    did_pop   = 0;
    if (in_frame) begin
      t++;
      if (t == 10 * DIV) in_frame = 0;
    end else if (pre_size != 0) begin
      cur       = q.pop_front();
      in_frame  = 1;
      t         = 0;
      did_pop   = 1;
      start_cyc = cyc;
    end
    if (push) begin
      if (pre_size < DEPTH || did_pop) q.push_back(wdata[7:0]);
      else begin
        ovf = 1;
        if (drops < 255) drops++;
      end
    end
    exp_tx   = in_frame ? frame_bit(cur, t) : 1'b1;
    exp_busy = in_frame || (q.size() != 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      check("uart_tx", 32'(uart_tx), 32'(exp_tx));
      check("busy",    32'(busy),    32'(exp_busy));
      check("sel",     32'(sel),     32'(exp_sel));
      check("rdata",   rdata,        exp_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic bit cond(input int mode);
    case (mode)
      0:       return in_frame && (t == 0);
      1:       return !exp_busy;
      2:       return !in_frame && (q.size() == DEPTH);
      default: return in_frame && (t == 4 * DIV + 3);
    endcase
  endfunction

  task automatic wait_for(input int mode, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(mode) && n < 2000);
    if (!cond(mode)) begin
      checks++;
      errors++;
      $display("FAIL %s: wait expired after %0d cycles", name, n);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic s);
    add   = a;
    wen   = 4'b0;
    wdata = '0;
    @(negedge clk);
    add = '0;
    rd  = rdata;
    s   = sel;
  endtask

  // ---------------- directed scenarios ----------------
  bit          a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  logic [31:0] frame_stat[3] = '{32'h0000_0201, 32'h0000_0101, 32'h0000_0005};
  logic [31:0] rd;
  logic        s;
  int          prev_start;

  initial begin
    reset = 1'b1;
    add   = '0;
    wen   = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'h1);
    check("rst_busy",    32'(busy),    32'h0);
    check("rst_sel",     32'(sel),     32'h0);
    check("rst_rdata",   rdata,        32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: latency, bit order, stop, busy release.
    add = ADDR_DATA; wen = 4'b0001; wdata = 32'h0000_00a5;
    @(negedge clk);
    add = '0; wen = '0; wdata = '0;
    check("t1_before_fall", 32'(uart_tx), 32'h1);
    @(negedge clk);
    check("t1_fall", 32'(uart_tx), 32'h0);
    repeat (DIV / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      check($sformatf("t1_bit%0d", i), 32'(uart_tx), 32'(a5_bits[i]));
    end
    repeat (DIV) @(negedge clk);
    check("t1_stop", 32'(uart_tx), 32'h1);
    repeat (DIV / 2 - 1) @(negedge clk);
    check("t1_busy_last", 32'(busy), 32'h1);
    @(negedge clk);
    check("t1_busy_drop", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);

    // Register reads while idle.
    bus_read(ADDR_STAT, rd, s);
    check("t3_stat_sel", 32'(s), 32'h1);
    check("t3_stat_rdata", rd, 32'h0000_0004);
    bus_read(ADDR_DATA, rd, s);
    check("t3_data_sel", 32'(s), 32'h1);
    check("t3_data_rdata", rd, 32'h0);
    bus_read(32'h0000_0100, rd, s);
    check("t3_other_sel", 32'(s), 32'h0);
    repeat (2) @(negedge clk);

    // Four back-to-back bytes: frame period and count at each frame start.
    for (int i = 0; i < 4; i++) begin
      add = ADDR_DATA; wen = 4'b1111; wdata = 32'(i + 1);
      @(negedge clk);
    end
    bus_read(ADDR_STAT, rd, s);
    check("t2_count3", rd, 32'h0000_0301);
    prev_start = start_cyc;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, $sformatf("t2_frame%0d", k + 2));
      check($sformatf("t2_period%0d", k + 2), 32'(start_cyc - prev_start), 32'd101);
      prev_start = start_cyc;
      bus_read(ADDR_STAT, rd, s);
      check($sformatf("t2_stat_frame%0d", k + 2), rd, frame_stat[k]);
    end
    wait_for(1, "t2_idle");
    repeat (2) @(negedge clk);

    // Six consecutive bytes into DEPTH=4: one popped, four held, one dropped.
    for (int i = 0; i < 6; i++) begin
      add = ADDR_DATA; wen = 4'b0001; wdata = 32'h10 + 32'(i);
      @(negedge clk);
    end
    bus_read(ADDR_STAT, rd, s);
    check("t4_overflow_stat", rd, 32'h0000_040b | DROP1);

    // Push while full on the same edge the serializer pops.
    wait_for(2, "t5_idle_full");
    add = ADDR_DATA; wen = 4'b0001; wdata = 32'h77;
    @(negedge clk);
    bus_read(ADDR_STAT, rd, s);
    check("t5_push_pop_full", rd, 32'h0000_040b | DROP1);

    // Reset during data bit 3 with two bytes queued.
    reset = 1'b1; add = '0; wen = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      add = ADDR_DATA; wen = 4'b0001; wdata = 32'h31 + 32'(i);
      @(negedge clk);
    end
    add = '0; wen = '0; wdata = '0;
    wait_for(3, "t6_bit3");
    check("t6_queued", 32'(q.size()), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("t6_tx_after_reset", 32'(uart_tx), 32'h1);
    check("t6_busy_after_reset", 32'(busy), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    bus_read(ADDR_STAT, rd, s);
    check("t6_stat_after_reset", rd, 32'h0000_0004);
    repeat (250) @(negedge clk);
    check("t6_quiet_tx", 32'(uart_tx), 32'h1);
    check("t6_quiet_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, limit 1000000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
